ospfb_frame_sink: RTL and testbench

Receiving end of the OSPFB output stream. Captures FFT output frames (tdata/tvalid/tlast/tuser, no backpressure available upstream) into a ping-pong frame buffer, checks frame framing, and re-emits whole frames on an AXI-Stream master that honours tready. Frames that cannot be buffered or that arrive malformed are dropped and counted; the upstream stream is never stalled.

---
 rtl/ospfb_frame_sink.sv | 279 +++++++++++++++++++++++++++
 tb/tb_ospfb_frame_sink.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_frame_sink.sv
// ospfb_frame_sink: receives FFT output frames from a stream with no backpressure, holds them
// in a ping-pong frame buffer, and re-emits only complete, well-formed frames on an
// AXI-Stream master. The upstream stream is never stalled.
// Optional build macro OSPFB_SINK_IDX_CHECK_EN: when defined, s_axis_tuser is checked against
// the expected bin index on every beat that is written.
//
// Writer FSM
//   state     | meaning
//   WR_FILL   | writing the frame into buf[wr_sel], or waiting for its first beat
//   WR_DROP   | frame arrived while buf[wr_sel] was full; counting beats until its end
//   WR_RESYNC | framing was lost; ignoring beats up to and including the next tlast
// Reader FSM
//   state     | meaning
//   RD_IDLE   | waiting for buf[iss_sel] to become full
//   RD_SEND   | issuing reads of buf[iss_sel] into the output skid
module ospfb_frame_sink #(
  parameter int WIDTH    = 16,
  parameter int FFT_LEN  = 32,
  parameter int USER_WID = 8,
  parameter int CNT_WID  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic [USER_WID-1:0]  s_axis_tuser,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [USER_WID-1:0]  m_axis_tuser,
  output logic [CNT_WID-1:0]   frame_cnt,
  output logic [CNT_WID-1:0]   drop_cnt,
  output logic                 err_tlast_unexpected,
  output logic                 err_tlast_missing,
  output logic                 err_index
);

  localparam int DW    = 2*WIDTH;
  localparam int IDX_W = $clog2(FFT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN-1);

  typedef enum logic [1:0] {WR_FILL, WR_DROP, WR_RESYNC} wr_state_t;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  wr_state_t           wr_state_q, wr_state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                wr_sel_q, wr_sel_d;
  logic [1:0]          full_q, full_d;
  logic                mem_we, full_set, drop_inc, idx_bad;
  logic                err_unexp_q, err_unexp_d;
  logic                err_miss_q, err_miss_d;
  logic                err_idx_q, err_idx_d;

  rd_state_t           rd_state_q, rd_state_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic                iss_sel_q, iss_sel_d;
  logic                rel_sel_q, rel_sel_d;
  logic                issue, pop, fifo_space, frame_done;

  logic [DW-1:0]       fifo_data_q [2];
  logic [DW-1:0]       fifo_data_d [2];
  logic [1:0]          fifo_last_q, fifo_last_d;
  logic [IDX_W-1:0]    fifo_idx_q [2];
  logic [IDX_W-1:0]    fifo_idx_d [2];
  logic                fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;

  logic [CNT_WID-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WID-1:0]  drop_cnt_q, drop_cnt_d;

  logic [DW-1:0]       mem_q [0:1][0:FFT_LEN-1];

  // tuser only feeds the optional index check; fold it so it never appears dangling
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  // Writer: classify each incoming beat and decide where it goes
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_sel_d    = wr_sel_q;
    mem_we      = 1'b0;
    full_set    = 1'b0;
    drop_inc    = 1'b0;
    err_unexp_d = 1'b0;
    err_miss_d  = 1'b0;
    err_idx_d   = 1'b0;
    idx_bad     = 1'b0;
`ifdef OSPFB_SINK_IDX_CHECK_EN
    idx_bad     = (IDX_W'(s_axis_tuser) != wr_idx_q);
`endif
    if (s_axis_tvalid) begin
      case (wr_state_q)
        WR_FILL: begin
          if (wr_idx_q == '0 && full_q[wr_sel_q]) begin
            // No room: this beat is the first beat of a dropped frame
            if (s_axis_tlast) begin
              drop_inc = 1'b1;
            end else begin
              wr_idx_d    = wr_idx_q + 1'b1;
              wr_state_d  = WR_DROP;
            end
          end else if (idx_bad) begin
            err_idx_d  = 1'b1;
            drop_inc   = 1'b1;
            wr_idx_d   = '0;
            wr_state_d = s_axis_tlast ? WR_FILL : WR_RESYNC;
          end else if (s_axis_tlast) begin
            wr_idx_d = '0;
            if (wr_idx_q == LAST_IDX) begin
              mem_we   = 1'b1;
              full_set = 1'b1;
              wr_sel_d = ~wr_sel_q;
            end else begin
              err_unexp_d = 1'b1;
              drop_inc    = 1'b1;
            end
          end else if (wr_idx_q == LAST_IDX) begin
            err_miss_d = 1'b1;
            drop_inc   = 1'b1;
            wr_idx_d   = '0;
            wr_state_d = WR_RESYNC;
          end else begin
            mem_we   = 1'b1;
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            drop_inc   = 1'b1;
            wr_idx_d   = '0;
            wr_state_d = WR_FILL;
          end else if (wr_idx_q == LAST_IDX) begin
            drop_inc   = 1'b1;
            wr_idx_d   = '0;
            wr_state_d = WR_RESYNC;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
        WR_RESYNC: begin
          if (s_axis_tlast) begin
            wr_idx_d   = '0;
            wr_state_d = WR_FILL;
          end
        end
        default: begin
          wr_idx_d   = '0;
          wr_state_d = WR_FILL;
        end
      endcase
    end
  end

  // Frame buffer storage; no reset needed since full flags gate every read
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_sel_q][wr_idx_q] <= s_axis_tdata;
  end

  // Output side handshakes: skid pop, read-issue space, and frame release on the tlast beat
  always_comb begin
    pop        = (fifo_cnt_q != 2'd0) && m_axis_tready;
    fifo_space = (fifo_cnt_q != 2'd2) || pop;
    frame_done = pop && fifo_last_q[fifo_rp_q];
  end

  // Reader: walk the committed buffer, rolling straight into the other one if it is also full
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    iss_sel_d  = iss_sel_q;
    issue      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[iss_sel_q]) rd_state_d = RD_SEND;
      end
      RD_SEND: begin
        if (fifo_space) begin
          issue = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d  = '0;
            iss_sel_d = ~iss_sel_q;
            if (!full_q[~iss_sel_q]) rd_state_d = RD_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Skid FIFO (the registered memory read lands directly in it), full flags and counters
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, issue} - {1'b0, pop};
    if (issue) begin
      fifo_data_d[fifo_wp_q] = mem_q[iss_sel_q][rd_idx_q];
      fifo_last_d[fifo_wp_q] = (rd_idx_q == LAST_IDX);
      fifo_idx_d[fifo_wp_q]  = rd_idx_q;
      fifo_wp_d              = ~fifo_wp_q;
    end
    if (pop) fifo_rp_d = ~fifo_rp_q;

    full_d      = full_q;
    rel_sel_d   = rel_sel_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_done) begin
      full_d[rel_sel_q] = 1'b0;
      rel_sel_d         = ~rel_sel_q;
      frame_cnt_d       = frame_cnt_q + 1'b1;
    end
    // A buffer is only set while empty, so it never collides with a release of the same buffer
    if (full_set) full_d[wr_sel_q] = 1'b1;
    drop_cnt_d = drop_inc ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WR_FILL;
      wr_idx_q    <= '0;
      wr_sel_q    <= 1'b0;
      full_q      <= '0;
      err_unexp_q <= 1'b0;
      err_miss_q  <= 1'b0;
      err_idx_q   <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rd_idx_q    <= '0;
      iss_sel_q   <= 1'b0;
      rel_sel_q   <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '0;
      fifo_idx_q  <= '{default: '0};
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_idx_q    <= wr_idx_d;
      wr_sel_q    <= wr_sel_d;
      full_q      <= full_d;
      err_unexp_q <= err_unexp_d;
      err_miss_q  <= err_miss_d;
      err_idx_q   <= err_idx_d;
      rd_state_q  <= rd_state_d;
      rd_idx_q    <= rd_idx_d;
      iss_sel_q   <= iss_sel_d;
      rel_sel_q   <= rel_sel_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      fifo_idx_q  <= fifo_idx_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      fifo_cnt_q  <= fifo_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_axis_tdata         = fifo_data_q[fifo_rp_q];
  assign m_axis_tvalid        = (fifo_cnt_q != 2'd0);
  assign m_axis_tlast         = fifo_last_q[fifo_rp_q];
  assign m_axis_tuser         = USER_WID'(fifo_idx_q[fifo_rp_q]);
  assign frame_cnt            = frame_cnt_q;
  assign drop_cnt             = drop_cnt_q;
  assign err_tlast_unexpected = err_unexp_q;
  assign err_tlast_missing    = err_miss_q;
  assign err_index            = err_idx_q;

endmodule

// File: tb/tb_ospfb_frame_sink.sv
// tb_ospfb_frame_sink: directed scenarios with random payloads; expected frames and counters
// come from a frame-level model of the acceptance rules.
module tb_ospfb_frame_sink;
  localparam int WIDTH = 16, L = 32, USER_WID = 8, CNT_WID = 32;
  localparam int DW = 2*WIDTH;
`ifdef OSPFB_SINK_IDX_CHECK_EN
  localparam bit IDX_CHK = 1'b1;
`else
  localparam bit IDX_CHK = 1'b0;
`endif

  typedef enum {F_ACCEPT, F_FULL, F_UNEXP, F_MISS, F_IDX} fate_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [USER_WID-1:0] s_tuser = '0;
  logic m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tlast;
  logic [USER_WID-1:0] m_tuser;
  logic [CNT_WID-1:0] frame_cnt, drop_cnt;
  logic err_unexp, err_miss, err_idx;

  ospfb_frame_sink #(.WIDTH(WIDTH), .FFT_LEN(L), .USER_WID(USER_WID), .CNT_WID(CNT_WID)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .err_tlast_unexpected(err_unexp), .err_tlast_missing(err_miss), .err_index(err_idx));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [DW-1:0] got_data[$];
  logic got_last[$];
  logic [USER_WID-1:0] got_user[$];
  int got_cyc[$];
  logic [DW-1:0] exp_data[$];
  int exp_bin[$];
  int pulses_unexp = 0, pulses_miss = 0, pulses_idx = 0;
  int exp_unexp = 0, exp_miss = 0, exp_idx = 0, exp_frames = 0, exp_drops = 0;
  int held = 0;
  bit rnd_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW+USER_WID:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects handshaken beats, counts error pulses, checks AXIS hold rule
  always @(negedge clk) begin
    if (err_unexp) pulses_unexp++;
    if (err_miss) pulses_miss++;
    if (err_idx) pulses_idx++;
    if (prev_stall && !rst)
      chk("axis_hold", {m_tvalid, m_tdata, m_tlast, m_tuser}, {1'b1, prev_beat});
    if (m_tvalid && m_tready && !rst) begin
      got_data.push_back(m_tdata);
      got_last.push_back(m_tlast);
      got_user.push_back(m_tuser);
      got_cyc.push_back(cyc);
    end
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_beat = {m_tdata, m_tlast, m_tuser};
  end

  // Random downstream readiness, only while enabled
  always @(posedge clk) begin
    if (rnd_ready) begin
      #2;
      if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  // Frame-level rule: walk beats in order, the first framing event decides the frame's fate
  function automatic fate_t frame_fate(input int tlast_at, input int bad_at);
    if (held >= 2) return F_FULL;
    for (int k = 0; k < L; k++) begin
      if (IDX_CHK && k == bad_at) return F_IDX;
      if (k == tlast_at) return (k == L-1) ? F_ACCEPT : F_UNEXP;
      if (k == L-1) return F_MISS;
    end
    return F_MISS;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic [USER_WID-1:0] u);
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic send_frame(input int nbeats, input int tlast_at, input int bad_at);
    logic [DW-1:0] d[$];
    fate_t f;
    for (int k = 0; k < nbeats; k++) d.push_back(DW'($urandom));
    f = frame_fate(tlast_at, bad_at);
    case (f)
      F_ACCEPT: begin
        for (int k = 0; k < L; k++) begin exp_data.push_back(d[k]); exp_bin.push_back(k); end
        exp_frames++; held++;
      end
      F_FULL:  exp_drops++;
      F_UNEXP: begin exp_drops++; exp_unexp++; end
      F_MISS:  begin exp_drops++; exp_miss++; end
      default: begin exp_drops++; exp_idx++; end
    endcase
    for (int k = 0; k < nbeats; k++)
      drive(1'b1, d[k], k == tlast_at, USER_WID'((k == bad_at) ? k + 1 : k));
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    for (int i = 0; i < 3000 && got_data.size() < n; i++) tick();
    chk({tag, "_timeout"}, 64'(got_data.size() >= n), 64'd1);
  endtask

  task automatic compare_all(input string tag);
    int n;
    idle(5);
    chk({tag, "_beats"}, 64'(got_data.size()), 64'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), {got_data[i], got_last[i], got_user[i]},
          {exp_data[i], exp_bin[i] == L-1, USER_WID'(exp_bin[i])});
    got_data.delete(); got_last.delete(); got_user.delete(); got_cyc.delete();
    exp_data.delete(); exp_bin.delete();
    held = 0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drops));
    chk({tag, "_err_unexp"}, 64'(pulses_unexp), 64'(exp_unexp));
    chk({tag, "_err_miss"}, 64'(pulses_miss), 64'(exp_miss));
    chk({tag, "_err_idx"}, 64'(pulses_idx), 64'(exp_idx));
  endtask

  initial begin
    int kind, p;
    // Reset state
    rst = 1'b1;
    idle(3);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast_tuser", {m_tlast, m_tuser}, 64'd0);
    check_counters("rst");
    rst = 1'b0;
    idle(2);

    // Three good frames streamed with short gaps, tready high
    m_tready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      held = 0;
      send_frame(L, L-1, -1);
      idle(6);
    end
    wait_out(exp_data.size(), "t1");
    compare_all("t1");
    check_counters("t1");

    // tready low: two frames buffered, two dropped, then drained back-to-back
    m_tready = 1'b0;
    held = 0;
    for (int f = 0; f < 4; f++) begin
      send_frame(L, L-1, -1);
      idle(6);
    end
    idle(48);
    chk("t2_drop_cnt_stalled", 64'(drop_cnt), 64'(exp_drops));
    chk("t2_frame_cnt_stalled", 64'(frame_cnt), 64'(exp_frames - held));
    m_tready = 1'b1;
    wait_out(exp_data.size(), "t2");
    if (got_cyc.size() >= 2*L)
      chk("t2_no_gap", 64'(got_cyc[2*L-1] - got_cyc[0]), 64'(2*L-1));
    else
      chk("t2_no_gap_beats", 64'(got_cyc.size()), 64'(2*L));
    compare_all("t2");
    check_counters("t2");

    // Early tlast on bin 10, then a good frame
    send_frame(11, 10, -1);
    idle(6);
    held = 0;
    send_frame(L, L-1, -1);
    wait_out(exp_data.size(), "t3");
    compare_all("t3");
    check_counters("t3");

    // Missing tlast, five resync beats, then a good frame
    send_frame(L, -1, -1);
    for (int k = 0; k < 5; k++) drive(1'b1, DW'($urandom), k == 4, '0);
    idle(3);
    held = 0;
    send_frame(L, L-1, -1);
    wait_out(exp_data.size(), "t4");
    compare_all("t4");
    check_counters("t4");

    // Wrong bin index at bin 6, then a good frame
    send_frame(L, L-1, 6);
    idle(6);
    held = 0;
    send_frame(L, L-1, -1);
    wait_out(exp_data.size(), "t5");
    compare_all("t5");
    check_counters("t5");

    // Randomised frame kinds with random downstream readiness
    rnd_ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      held = 0;
      if (kind == 0) send_frame(L, L-1, -1);
      else if (kind == 1) begin
        p = $urandom_range(0, L-2);
        send_frame(p + 1, p, -1);
      end else send_frame(L, L-1, $urandom_range(0, L-1));
      wait_out(exp_data.size(), "rnd");
      idle(4);
    end
    rnd_ready = 1'b0;
    #3;
    m_tready = 1'b1;
    compare_all("rnd");
    check_counters("rnd");

    // Reset in the middle of an outgoing frame
    held = 0;
    send_frame(L, L-1, -1);
    wait_out(12, "t6_pre");
    rst = 1'b1;
    #1;
    chk("t6_tvalid_in_reset", 64'(m_tvalid), 64'd0);
    chk("t6_frame_cnt_reset", 64'(frame_cnt), 64'd0);
    chk("t6_drop_cnt_reset", 64'(drop_cnt), 64'd0);
    got_data.delete(); got_last.delete(); got_user.delete(); got_cyc.delete();
    exp_data.delete(); exp_bin.delete();
    exp_frames = 0; exp_drops = 0; held = 0;
    idle(2);
    rst = 1'b0;
    idle(2);
    send_frame(L, L-1, -1);
    wait_out(exp_data.size(), "t6");
    compare_all("t6");
    check_counters("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
